// File: rtl/pc_stack_unit_pkg.sv
// Shared types, defaults and helpers for the program counter / return stack unit.
package pc_stack_unit_pkg;

    localparam int unsigned DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam int unsigned DEFAULT_IRQ_VEC   = 32'h0000_00F8;

    // Control strobes arriving from the sequencer in one cycle.
    typedef struct packed {
        logic advance;
        logic do_jump;
        logic do_call;
        logic do_return;
        logic do_reti;
        logic set_ie;
        logic clr_ie;
    } ctrl_strobes_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// LIFO return-address stack; only the occupancy counter is reset.
module pc_stack_unit_return_stack
    import pc_stack_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic [clog2(DEPTH+1)-1:0]     depth,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned DW = clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic [DW-1:0]    top;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign full   = (depth_q == DW'(DEPTH));
    assign empty  = (depth_q == '0);
    assign top    = depth_q - DW'(1);
    assign wr_idx = depth_q[AW-1:0];
    assign rd_idx = top[AW-1:0];
    assign dout   = mem[rd_idx];
    assign depth  = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (push && !full) begin
            depth_d = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // A push into a full stack is dropped rather than overwriting the top entry.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with hardware return stack and a single vectored, maskable interrupt.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RESET_VEC = DEFAULT_RESET_VEC,
    parameter int unsigned IRQ_VEC   = DEFAULT_IRQ_VEC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      advance,
    input  logic                      doJump,
    input  logic                      doCall,
    input  logic                      doReturn,
    input  logic                      doReti,
    input  logic                      setIE,
    input  logic                      clrIE,
    input  logic                      instrBoundary,
    input  logic                      irqReq,
    input  logic [WIDTH-1:0]          dbus,
    output logic [WIDTH-1:0]          pc,
    output logic [clog2(DEPTH+1)-1:0] depth,
    output logic                      ie,
    output logic                      inIrq,
    output logic                      irqAck,
    output logic                      overflow,
    output logic                      underflow
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] IRQ_PC = WIDTH'(IRQ_VEC);

    ctrl_strobes_t    strb;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             ie_q, ie_d;
    logic             in_irq_q, in_irq_d;
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             irq_take;
    logic             push, pop;
    logic [WIDTH-1:0] stk_dout;
    logic             stk_full, stk_empty;

    assign strb = '{
        advance:   advance,
        do_jump:   doJump,
        do_call:   doCall,
        do_return: doReturn,
        do_reti:   doReti,
        set_ie:    setIE,
        clr_ie:    clrIE
    };

    assign irq_take = instrBoundary && irqReq && ie_q && !in_irq_q;

    pc_stack_unit_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_q),
        .dout  (stk_dout),
        .depth (depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Exactly one action per cycle, highest priority first.
    always_comb begin
        pc_d     = pc_q;
        ie_d     = ie_q;
        in_irq_d = in_irq_q;
        ack_d    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;

        if (irq_take) begin
            push     = 1'b1;
            pc_d     = IRQ_PC;
            in_irq_d = 1'b1;
            ack_d    = 1'b1;
        end else if (strb.do_reti) begin
            pop      = 1'b1;
            ie_d     = 1'b1;
            in_irq_d = 1'b0;
            if (!stk_empty) pc_d = stk_dout;
        end else if (strb.do_return) begin
            pop = 1'b1;
            if (!stk_empty) pc_d = stk_dout;
        end else if (strb.do_call) begin
            push = 1'b1;
            pc_d = dbus;
        end else if (strb.do_jump) begin
            pc_d = dbus;
        end else if (strb.advance) begin
            pc_d = pc_q + WIDTH'(1);
        end

        // Interrupt entry always masks; otherwise clrIE beats setIE.
        if (irq_take) begin
            ie_d = 1'b0;
        end else if (strb.clr_ie) begin
            ie_d = 1'b0;
        end else if (strb.set_ie) begin
            ie_d = 1'b1;
        end

        ovf_d = ovf_q | (push & stk_full);
        unf_d = unf_q | (pop & stk_empty);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RST_PC;
            ie_q     <= 1'b0;
            in_irq_q <= 1'b0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ie_q     <= ie_d;
            in_irq_q <= in_irq_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign pc        = pc_q;
    assign ie        = ie_q;
    assign inIrq     = in_irq_q;
    assign irqAck    = ack_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios plus random strobes vs a queue model.
module tb_pc_stack_unit;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          advance, doJump, doCall, doReturn, doReti, setIE, clrIE;
    logic          instrBoundary, irqReq;
    logic [W-1:0]  dbus;
    logic [W-1:0]  pc;
    logic [DW-1:0] depth;
    logic          ie, inIrq, irqAck, overflow, underflow;

    always #5 clk = ~clk;

    pc_stack_unit #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VEC (0),
        .IRQ_VEC   ('hF8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .advance       (advance),
        .doJump        (doJump),
        .doCall        (doCall),
        .doReturn      (doReturn),
        .doReti        (doReti),
        .setIE         (setIE),
        .clrIE         (clrIE),
        .instrBoundary (instrBoundary),
        .irqReq        (irqReq),
        .dbus          (dbus),
        .pc            (pc),
        .depth         (depth),
        .ie            (ie),
        .inIrq         (inIrq),
        .irqAck        (irqAck),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_ie, m_inirq, m_ack, m_ovf, m_unf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int value);
        if (m_stk.size() < D) m_stk.push_back(value);
        else m_ovf = 1'b1;
    endtask

    task automatic model_pop();
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else m_unf = 1'b1;
    endtask

    task automatic model_step();
        if (!reset) begin
            m_pc = 0; m_stk.delete();
            m_ie = 0; m_inirq = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
        end else if (instrBoundary && irqReq && m_ie && !m_inirq) begin
            model_push(m_pc);
            m_pc = 'hF8; m_ie = 0; m_inirq = 1; m_ack = 1;
        end else begin
            m_ack = 0;
            if (doReti) begin
                model_pop(); m_ie = 1; m_inirq = 0;
            end else if (doReturn) begin
                model_pop();
            end else if (doCall) begin
                model_push(m_pc); m_pc = int'(dbus);
            end else if (doJump) begin
                m_pc = int'(dbus);
            end else if (advance) begin
                m_pc = (m_pc + 1) % 256;
            end
            if (clrIE) m_ie = 0;
            else if (setIE) m_ie = 1;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_eq({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check_eq({tag, ".depth"}, 32'(depth), 32'(m_stk.size()));
        check_eq({tag, ".ie"}, 32'(ie), 32'(m_ie));
        check_eq({tag, ".inIrq"}, 32'(inIrq), 32'(m_inirq));
        check_eq({tag, ".irqAck"}, 32'(irqAck), 32'(m_ack));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic apply(input bit adv, input bit jmp, input bit call, input bit ret,
                         input bit rti, input bit sie, input bit cie, input bit ib,
                         input bit irq, input int tgt, input string tag);
        advance = adv; doJump = jmp; doCall = call; doReturn = ret; doReti = rti;
        setIE = sie; clrIE = cie; instrBoundary = ib; irqReq = irq; dbus = tgt[W-1:0];
        tick(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        reset = 1'b1;
    endtask

    initial begin
        int ret_exp[5];
        ret_exp = '{'h52, 'h51, 'h50, 'h10, 'h10};

        do_reset();
        check_eq("rst_pc", 32'(pc), 32'h0);
        check_eq("rst_depth", 32'(depth), 32'h0);

        // Free-running advance across the wrap point
        for (int i = 0; i < 259; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "adv");
            if (i == 255) check_eq("wrap_pc", 32'(pc), 32'h0);
        end
        check_eq("wrap_end", 32'(pc), 32'h3);

        // Single call/return
        do_reset();
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 'h10, "jmp");
        apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 'h40, "call");
        check_eq("call_pc", 32'(pc), 32'h40);
        check_eq("call_depth", 32'(depth), 32'h1);
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "ret");
        check_eq("ret_pc", 32'(pc), 32'h10);
        check_eq("ret_depth", 32'(depth), 32'h0);

        // Nested calls beyond capacity, then unwind past empty
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 'h50 + i, "ncall");
        check_eq("nest_depth", 32'(depth), 32'h4);
        check_eq("nest_ovf", 32'(overflow), 32'h1);
        check_eq("nest_pc", 32'(pc), 32'h54);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "nret");
            check_eq("nret_pc", 32'(pc), 32'(ret_exp[i]));
        end
        check_eq("nret_unf", 32'(underflow), 32'h1);

        // Interrupt entry preempting a jump, no nesting, reti, re-entry
        do_reset();
        apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "seti");
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 'h23, "jmp");
        apply(0, 1, 0, 0, 0, 0, 0, 1, 1, 'h80, "irq");
        check_eq("irq_pc", 32'(pc), 32'hF8);
        check_eq("irq_ack", 32'(irqAck), 32'h1);
        check_eq("irq_ie", 32'(ie), 32'h0);
        check_eq("irq_in", 32'(inIrq), 32'h1);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "hnd");
        check_eq("ack_pulse", 32'(irqAck), 32'h0);
        check_eq("no_nest", 32'(pc), 32'hF9);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "hnd");
        apply(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, "reti");
        check_eq("reti_pc", 32'(pc), 32'h23);
        check_eq("reti_ie", 32'(ie), 32'h1);
        check_eq("reti_in", 32'(inIrq), 32'h0);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "reirq");
        check_eq("reirq_pc", 32'(pc), 32'hF8);

        // Masked or off-boundary requests are ignored
        do_reset();
        apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 'h30, "jmp");
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "masked");
        check_eq("masked_pc", 32'(pc), 32'h31);
        apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "seti");
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "nobnd");
        check_eq("nobnd_pc", 32'(pc), 32'h32);

        // Reset asserted mid-handler with stack and sticky flags live
        do_reset();
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 0, 0, 0, 0, 0, 'h60 + i, "mcall");
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "mret");
        apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "seti");
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "mirq");
        check_eq("mid_depth", 32'(depth), 32'h2);
        check_eq("mid_ovf", 32'(overflow), 32'h1);
        check_eq("mid_in", 32'(inIrq), 32'h1);
        reset = 1'b0;
        apply(1, 0, 1, 0, 1, 1, 0, 1, 1, 'h77, "midrst");
        reset = 1'b1;
        check_eq("midrst_pc", 32'(pc), 32'h0);
        check_eq("midrst_depth", 32'(depth), 32'h0);
        check_eq("midrst_ovf", 32'(overflow), 32'h0);
        check_eq("midrst_in", 32'(inIrq), 32'h0);

        // Random strobes against the model
        for (int i = 0; i < 3000; i++) begin
            bit rti;
            reset = ($urandom_range(0, 199) != 0);
            rti = ($urandom_range(0, 99) < 5);
            apply($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12, rti,
                  !rti && ($urandom_range(0, 99) < 10), !rti && ($urandom_range(0, 99) < 5),
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
                  int'($urandom_range(0, 255)), "rnd");
        end
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
